ir_nec_decoder: RTL and testbench
=================================

Name: ir_nec_decoder

Overview:
- Consumes the 17.778 kHz nec_clk square wave (period 56.25 us = 1/10 of the NEC 562.5 us unit) produced by the IR timebase generator.
- Uses nec_clk as a sampling tick to measure mark/space widths on the demodulated IR receiver output.
- Decodes NEC frames (leader, 32 data bits LSB-first, stop mark) and repeat codes into addr/cmd with single-cycle strobes; the game-control logic consumes them.

Parameters:
- MAX_TICKS, 200, timeout: ticks without an ir level change in any non-IDLE state aborts the frame.
- CHECK_INV, 1, 1 = require addr_n==~addr and cmd_n==~cmd for valid; 0 = accept any value (extended NEC).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- nec_clk  in  1  timebase square wave; sampling tick = its rising edge
- ir_in  in  1  raw receiver output, asynchronous, active-low (0 = carrier present = mark)
- addr  out  8  last valid address; held until next valid
- cmd  out  8  last valid command; held until next valid
- valid  out  1  one-clk pulse: new frame accepted
- rpt  out  1  one-clk pulse: repeat code accepted
- err  out  1  one-clk pulse: frame aborted
- busy  out  1  high whenever FSM not in IDLE

Behaviour:
- Reset: addr=0, cmd=0, valid=0, rpt=0, err=0, busy=0, FSM=IDLE, shift reg=0, bit count=0, tick count=0, sampled level=1.
- Reset mid-frame discards the frame. No pulse is emitted.
- ir_in and nec_clk each pass through 2-flop synchronizers.
- tick = 1 for one clk when synced nec_clk goes 0->1.
- All FSM/counter updates occur only on clk cycles with tick=1. ir level is sampled only on ticks.
- Width counter cnt (8 bit, saturating at 255):
  - On tick, if sample == previous sample: cnt<=cnt+1.
  - Else: evaluate duration=cnt for the level just ended, then cnt<=1.
- Windows in ticks, inclusive:
  - LEAD_MARK 144..176
  - LEAD_SPACE 72..88
  - RPT_SPACE 36..44
  - BIT_MARK / STOP_MARK 7..13
  - SPACE0 7..13
  - SPACE1 25..35
- FSM states and transitions:
  - IDLE: on falling level (mark start) -> LEAD_MARK.
  - LEAD_MARK: mark end in LEAD_MARK window -> LEAD_SPACE; else err.
  - LEAD_SPACE: space end in LEAD_SPACE window -> BIT_MARK with bitcnt=0; in RPT_SPACE window -> RPT_STOP; else err.
  - BIT_MARK: mark end in BIT_MARK window -> BIT_SPACE; else err.
  - BIT_SPACE: space end in SPACE0 shifts in 0, in SPACE1 shifts in 1, else err.
    - Shift: 32-bit reg, right-shift, new bit into [31], so the first bit received lands at [0].
    - After the shift, bitcnt<=bitcnt+1. Go -> BIT_MARK if bitcnt<31, else -> STOP.
  - STOP: mark end in STOP_MARK window:
    - If inversion check passes (or CHECK_INV=0): addr<=sr[7:0], cmd<=sr[23:16], valid pulse.
    - Otherwise err.
    - Either way -> IDLE.
  - RPT_STOP: mark end in STOP_MARK window -> rpt pulse, IDLE; else err.
- Abort conditions:
  - Any state other than IDLE: cnt reaches MAX_TICKS -> err pulse, IDLE.
  - err always returns to IDLE. IDLE then ignores input until a falling level is seen; a held-low line therefore re-enters LEAD_MARK only after a high sample.
- Latency: valid/rpt/err are registered. Each is high exactly on the clk cycle following the tick cycle on which the decision is made.
- Mutual exclusion: valid, rpt and err are never high simultaneously.
- addr/cmd change only in the same cycle valid rises. rpt and err leave them unchanged.
- Field layout: sr[15:8]=addr_n, sr[31:24]=cmd_n.

Decomposition:
- Package ir_nec_pkg holds:
  - state enum (IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP, RPT_STOP)
  - all window min/max localparams
  - the in_window(cnt,min,max) function
- Sub-module ir_sync_tick: 2-flop synchronizers for ir_in/nec_clk plus rising-edge tick generation. Outputs ir_s and tick.

Test Plan:
- Valid frame, bench drives nec_clk at 8 clk/period:
  - Stimulus: NEC addr=0x04, cmd=0x1A (sr=0xE51AFB04) with nominal widths 160/80/10/10|30/10.
  - Response: one valid pulse; addr=0x04, cmd=0x1A; busy low after.
- Repeat code:
  - Stimulus: 160-tick mark, 40-tick space, 10-tick mark.
  - Response: one rpt pulse; addr/cmd unchanged from the previous frame.
- Tolerance edges:
  - All widths at min (144/72/7/7/25) -> valid.
  - Leader mark at 143 -> err.
  - Bit space at 20 -> err.
- Inversion failure:
  - Stimulus: cmd_n=0x1A equal to cmd.
  - Response: err, no valid. With CHECK_INV=0 -> valid, cmd=0x1A.
- Timeout:
  - Stimulus: stop after 12 bits, line held high.
  - Response: err exactly after cnt reaches 200 ticks; busy=0 next cycle.
- Reset mid-frame:
  - Stimulus: assert reset_n=0 at bit 20.
  - Response: all outputs 0.
  - A subsequent full frame decodes with no err.

Source files
------------

// File: rtl/ir_nec_pkg.sv
// ir_nec_pkg: decoder states, NEC width windows in 56.25 us sampling ticks, and the window test.
package ir_nec_pkg;
   typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP, RPT_STOP} state_t;
   localparam logic [7:0] LEAD_MARK_MIN  = 8'd144;
   localparam logic [7:0] LEAD_MARK_MAX  = 8'd176;
   localparam logic [7:0] LEAD_SPACE_MIN = 8'd72;
   localparam logic [7:0] LEAD_SPACE_MAX = 8'd88;
   localparam logic [7:0] RPT_SPACE_MIN  = 8'd36;
   localparam logic [7:0] RPT_SPACE_MAX  = 8'd44;
   localparam logic [7:0] BIT_MARK_MIN   = 8'd7;
   localparam logic [7:0] BIT_MARK_MAX   = 8'd13;
   localparam logic [7:0] SPACE0_MIN     = 8'd7;
   localparam logic [7:0] SPACE0_MAX     = 8'd13;
   localparam logic [7:0] SPACE1_MIN     = 8'd25;
   localparam logic [7:0] SPACE1_MAX     = 8'd35;
   function automatic logic in_window(input logic [7:0] cnt, input logic [7:0] lo, input logic [7:0] hi);
      return (cnt >= lo) && (cnt <= hi);
   endfunction
endpackage

// File: rtl/ir_sync_tick.sv
// ir_sync_tick: 2-flop synchronizers for ir_in/nec_clk and a one-clk tick on each nec_clk rising edge.
module ir_sync_tick (
   input  logic clk,
   input  logic reset_n,
   input  logic nec_clk,
   input  logic ir_in,
   output logic ir_s,
   output logic tick
);
   logic [1:0] ir_q, ir_d;
   logic [2:0] nec_q, nec_d;
   always_comb begin
      ir_d  = {ir_q[0], ir_in};
      nec_d = {nec_q[1:0], nec_clk};
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ir_q  <= 2'b11;
         nec_q <= 3'b000;
      end else begin
         ir_q  <= ir_d;
         nec_q <= nec_d;
      end
   end
   assign ir_s = ir_q[1];
   assign tick = nec_q[1] & ~nec_q[2];
endmodule

// File: rtl/ir_nec_decoder.sv
// ir_nec_decoder: measures mark/space widths on nec_clk ticks and decodes NEC frames and repeat codes.
module ir_nec_decoder
   import ir_nec_pkg::*;
#(
   parameter int MAX_TICKS = 200,
   parameter bit CHECK_INV = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       nec_clk,
   input  logic       ir_in,
   output logic [7:0] addr,
   output logic [7:0] cmd,
   output logic       valid,
   output logic       rpt,
   output logic       err,
   output logic       busy
);
   localparam logic [7:0] MAX_T = 8'(MAX_TICKS);
   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d, cnt_inc;
   logic [31:0] sr_q, sr_d;
   logic [4:0]  bitcnt_q, bitcnt_d;
   logic        level_q, level_d;
   logic [7:0]  addr_q, addr_d, cmd_q, cmd_d;
   logic        valid_q, valid_d, rpt_q, rpt_d, err_q, err_d;
   logic        ir_s, tick, level_change, mark_ok, s0, s1, inv_ok;
   ir_sync_tick u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .nec_clk (nec_clk),
      .ir_in   (ir_in),
      .ir_s    (ir_s),
      .tick    (tick)
   );
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sr_d         = sr_q;
      bitcnt_d     = bitcnt_q;
      level_d      = level_q;
      addr_d       = addr_q;
      cmd_d        = cmd_q;
      valid_d      = 1'b0;
      rpt_d        = 1'b0;
      err_d        = 1'b0;
      cnt_inc      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      level_change = ir_s != level_q;
      mark_ok      = in_window(cnt_q, BIT_MARK_MIN, BIT_MARK_MAX);
      s0           = in_window(cnt_q, SPACE0_MIN, SPACE0_MAX);
      s1           = in_window(cnt_q, SPACE1_MIN, SPACE1_MAX);
      inv_ok       = !CHECK_INV || ((sr_q[15:8] == ~sr_q[7:0]) && (sr_q[31:24] == ~sr_q[23:16]));
      if (tick) begin
         level_d = ir_s;
         cnt_d   = level_change ? 8'd1 : cnt_inc;
         // cnt_q holds the width of the level that just ended
         if (!level_change) begin
            if (state_q != IDLE && cnt_inc >= MAX_T) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end else begin
            case (state_q)
               IDLE: state_d = ir_s ? IDLE : LEAD_MARK;
               LEAD_MARK: begin
                  state_d = in_window(cnt_q, LEAD_MARK_MIN, LEAD_MARK_MAX) ? LEAD_SPACE : IDLE;
                  err_d   = state_d == IDLE;
               end
               LEAD_SPACE: begin
                  bitcnt_d = 5'd0;
                  state_d  = in_window(cnt_q, LEAD_SPACE_MIN, LEAD_SPACE_MAX) ? BIT_MARK :
                             in_window(cnt_q, RPT_SPACE_MIN, RPT_SPACE_MAX) ? RPT_STOP : IDLE;
                  err_d    = state_d == IDLE;
               end
               BIT_MARK: begin
                  state_d = mark_ok ? BIT_SPACE : IDLE;
                  err_d   = !mark_ok;
               end
               BIT_SPACE: begin
                  sr_d     = (s0 || s1) ? {s1, sr_q[31:1]} : sr_q;
                  bitcnt_d = (s0 || s1) ? bitcnt_q + 5'd1 : bitcnt_q;
                  state_d  = !(s0 || s1) ? IDLE : (bitcnt_q == 5'd31) ? STOP : BIT_MARK;
                  err_d    = !(s0 || s1);
               end
               STOP: begin
                  valid_d = mark_ok && inv_ok;
                  err_d   = !valid_d;
                  addr_d  = valid_d ? sr_q[7:0] : addr_q;
                  cmd_d   = valid_d ? sr_q[23:16] : cmd_q;
                  state_d = IDLE;
               end
               RPT_STOP: begin
                  rpt_d   = mark_ok;
                  err_d   = !mark_ok;
                  state_d = IDLE;
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= 8'd0;
         sr_q     <= 32'd0;
         bitcnt_q <= 5'd0;
         level_q  <= 1'b1;
         addr_q   <= 8'd0;
         cmd_q    <= 8'd0;
         valid_q  <= 1'b0;
         rpt_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sr_q     <= sr_d;
         bitcnt_q <= bitcnt_d;
         level_q  <= level_d;
         addr_q   <= addr_d;
         cmd_q    <= cmd_d;
         valid_q  <= valid_d;
         rpt_q    <= rpt_d;
         err_q    <= err_d;
      end
   end
   assign addr  = addr_q;
   assign cmd   = cmd_q;
   assign valid = valid_q;
   assign rpt   = rpt_q;
   assign err   = err_q;
   assign busy  = state_q != IDLE;
endmodule

// File: tb/tb_ir_nec_decoder.sv
// tb_ir_nec_decoder: random NEC waveforms against a width-list reference model, scoreboarded on both CHECK_INV settings.
module tb_ir_nec_decoder;
   localparam int K_VALID = 0;
   localparam int K_RPT   = 1;
   localparam int K_ERR   = 2;
   typedef struct {
      int         kind;
      logic [7:0] addr;
      logic [7:0] cmd;
   } ev_t;
   logic       clk = 1'b0, nec_clk = 1'b0, reset_n, ir_in;
   logic [7:0] addr0, cmd0, addr1, cmd1;
   logic       valid0, rpt0, err0, busy0, valid1, rpt1, err1, busy1;
   int         checks = 0, errors = 0, nec_edges = 0, hi_edge = 0;
   int         err_edge[2];
   bit         pend[2];
   int         fw[$];
   ev_t        q0[$], q1[$];
   logic [7:0] m_addr[2], m_cmd[2];
   always #5 clk = ~clk;
   always #40 nec_clk = ~nec_clk;
   always @(posedge nec_clk) nec_edges <= nec_edges + 1;
   ir_nec_decoder dut (
      .clk(clk), .reset_n(reset_n), .nec_clk(nec_clk), .ir_in(ir_in),
      .addr(addr0), .cmd(cmd0), .valid(valid0), .rpt(rpt0), .err(err0), .busy(busy0)
   );
   ir_nec_decoder #(.CHECK_INV(1'b0)) dut_x (
      .clk(clk), .reset_n(reset_n), .nec_clk(nec_clk), .ir_in(ir_in),
      .addr(addr1), .cmd(cmd1), .valid(valid1), .rpt(rpt1), .err(err1), .busy(busy1)
   );
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, got, want, $time);
      end
   endtask
   function automatic bit inw(input int x, input int lo, input int hi);
      return x >= lo && x <= hi;
   endfunction
   function automatic int pick(input int mode, input int lo, input int nom, input int hi);
      return mode == 0 ? nom : mode == 1 ? lo : int'($urandom_range(hi, lo));
   endfunction
   function automatic void mk_frame(input logic [31:0] sr, input int mode);
      fw = {};
      fw.push_back(pick(mode, 144, 160, 176));
      fw.push_back(pick(mode, 72, 80, 88));
      for (int b = 0; b < 32; b++) begin
         fw.push_back(pick(mode, 7, 10, 13));
         fw.push_back(sr[b] ? pick(mode, 25, 30, 35) : pick(mode, 7, 10, 13));
      end
      fw.push_back(pick(mode, 7, 10, 13));
   endfunction
   function automatic logic [31:0] rnd_sr();
      logic [7:0] a, c;
      a = 8'($urandom);
      c = 8'($urandom);
      return {~c, c, ~a, a};
   endfunction
   // fw alternates mark/space starting with the leader mark; a list that stops early ends in a timeout
   function automatic int predict(input bit ci, output logic [31:0] sr);
      sr = 32'd0;
      if (fw.size() < 2 || !inw(fw[0], 144, 176)) return K_ERR;
      if (inw(fw[1], 36, 44)) return (fw.size() > 2 && inw(fw[2], 7, 13)) ? K_RPT : K_ERR;
      if (!inw(fw[1], 72, 88)) return K_ERR;
      for (int b = 0; b < 32; b++) begin
         if (fw.size() < 4 + 2 * b || !inw(fw[2 + 2 * b], 7, 13)) return K_ERR;
         if (inw(fw[3 + 2 * b], 25, 35)) sr[b] = 1'b1;
         else if (!inw(fw[3 + 2 * b], 7, 13)) return K_ERR;
      end
      if (fw.size() < 67 || !inw(fw[66], 7, 13)) return K_ERR;
      return (!ci || (sr[15:8] == ~sr[7:0] && sr[31:24] == ~sr[23:16])) ? K_VALID : K_ERR;
   endfunction
   task automatic expect_fw();
      logic [31:0] sr;
      ev_t x;
      for (int ii = 0; ii < 2; ii++) begin
         x.kind = predict(ii == 0, sr);
         if (x.kind == K_VALID) begin
            m_addr[ii] = sr[7:0];
            m_cmd[ii]  = sr[23:16];
         end
         x.addr = m_addr[ii];
         x.cmd  = m_cmd[ii];
         if (ii == 0) q0.push_back(x);
         else q1.push_back(x);
      end
   endtask
   task automatic seg(input logic lvl, input int n);
      ir_in = lvl;
      repeat (n) @(negedge nec_clk);
   endtask
   task automatic run(input int gap);
      expect_fw();
      for (int i = 0; i < fw.size(); i++) seg(i % 2 == 1, fw[i]);
      if (fw.size() % 2 == 0) seg(1'b0, 10);
      hi_edge = nec_edges;
      seg(1'b1, gap);
      chk("drain_inv", q0.size(), 0);
      chk("drain_noinv", q1.size(), 0);
      chk("busy_idle", {busy0, busy1}, 2'b00);
   endtask
   task automatic mon(input int ii, input logic v, input logic r, input logic e, input logic b,
                      input logic [7:0] a, input logic [7:0] c);
      ev_t x;
      int  n;
      if (pend[ii]) begin
         pend[ii] = 1'b0;
         chk($sformatf("busy_after_pulse%0d", ii), b, 1'b0);
      end
      if (!(v || r || e)) return;
      chk($sformatf("one_hot%0d", ii), $countones({v, r, e}), 1);
      n = ii == 0 ? q0.size() : q1.size();
      chk($sformatf("pulse_expected%0d", ii), n > 0, 1'b1);
      if (n == 0) return;
      if (ii == 0) x = q0.pop_front();
      else x = q1.pop_front();
      chk($sformatf("kind%0d", ii), v ? K_VALID : r ? K_RPT : K_ERR, x.kind);
      chk($sformatf("addr%0d", ii), a, x.addr);
      chk($sformatf("cmd%0d", ii), c, x.cmd);
      if (e) err_edge[ii] = nec_edges;
      pend[ii] = 1'b1;
   endtask
   always @(negedge clk) begin
      if (reset_n) begin
         mon(0, valid0, rpt0, err0, busy0, addr0, cmd0);
         mon(1, valid1, rpt1, err1, busy1, addr1, cmd1);
      end
   end
   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
   initial begin
      reset_n = 1'b0;
      ir_in   = 1'b1;
      m_addr  = '{8'd0, 8'd0};
      m_cmd   = '{8'd0, 8'd0};
      repeat (3) @(negedge clk);
      chk("rst_addr", {addr0, addr1}, 16'd0);
      chk("rst_cmd", {cmd0, cmd1}, 16'd0);
      chk("rst_valid", {valid0, valid1}, 2'b00);
      chk("rst_rpt", {rpt0, rpt1}, 2'b00);
      chk("rst_err", {err0, err1}, 2'b00);
      chk("rst_busy", {busy0, busy1}, 2'b00);
      reset_n = 1'b1;
      @(negedge nec_clk);
      seg(1'b1, 10);
      mk_frame(32'hE51AFB04, 0);
      run(20);
      chk("nominal_addr", addr0, 8'h04);
      chk("nominal_cmd", cmd0, 8'h1A);
      fw = {160, 40, 10};
      run(20);
      mk_frame(rnd_sr(), 1);
      run(20);
      fw = {143};
      run(20);
      mk_frame(rnd_sr(), 0);
      while (fw.size() > 14) void'(fw.pop_back());
      fw[13] = 20;
      run(20);
      mk_frame(32'h1A1AFB04, 0);
      run(20);
      chk("noinv_cmd", cmd1, 8'h1A);
      mk_frame(rnd_sr(), 0);
      while (fw.size() > 27) void'(fw.pop_back());
      run(210);
      chk("timeout_edge_inv", err_edge[0], hi_edge + 200);
      chk("timeout_edge_noinv", err_edge[1], hi_edge + 200);
      for (int i = 0; i < 2; i++) begin
         fw = {pick(2, 144, 160, 176), pick(2, 36, 40, 44), pick(2, 7, 10, 13)};
         run(20);
      end
      fw = {160, int'($urandom_range(71, 45))};
      run(20);
      mk_frame(rnd_sr(), 2);
      for (int i = 0; i < 42; i++) seg(i % 2 == 1, fw[i]);
      @(negedge clk);
      reset_n = 1'b0;
      ir_in   = 1'b1;
      repeat (2) @(negedge clk);
      chk("midrst_addr", {addr0, addr1}, 16'd0);
      chk("midrst_cmd", {cmd0, cmd1}, 16'd0);
      chk("midrst_pulses", {valid0, rpt0, err0, valid1, rpt1, err1}, 6'd0);
      chk("midrst_busy", {busy0, busy1}, 2'b00);
      m_addr  = '{8'd0, 8'd0};
      m_cmd   = '{8'd0, 8'd0};
      reset_n = 1'b1;
      @(negedge nec_clk);
      seg(1'b1, 10);
      mk_frame(rnd_sr(), 2);
      run(20);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
